// File: rtl/neptune_proportional_tuner.sv
// Single-input guitar tuner: counts pulse edges over a 1 s window, classifies the
// nearest standard-tuning string and shows note / deviation glyphs on one digit.
module neptune_proportional_tuner (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int unsigned CNT_W = 9;
    localparam int unsigned WIN_W = 16;
    localparam int unsigned DIF_W = 10;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned CFG_W = 3;
    localparam int unsigned DIV_W = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [DIV_W-1:0] DIV_MAX = '1;

    typedef enum logic [2:0] {
        NOTE_NONE, NOTE_E2, NOTE_A2, NOTE_D3, NOTE_G3, NOTE_B3, NOTE_E4
    } note_e;

    typedef enum logic [2:0] {
        PROX_NONE, PROX_FAR_LO, PROX_CLOSE_LO, PROX_EXACT, PROX_CLOSE_HI, PROX_FAR_HI
    } prox_e;

    logic [CFG_W-1:0] cfg_q;
    logic [2:0]       sync_q;
    logic [CNT_W-1:0] pulse_cnt_q;
    logic [CNT_W-1:0] lat_cnt_q;
    logic             lat_valid_q;
    logic [WIN_W-1:0] win_cnt_q;
    note_e            note_q;
    prox_e            prox_q;
    logic [DIV_W-1:0] div_q;
    logic             prox_sel_q;

    logic [CFG_W-1:0] cfg_c;
    logic             cfg_change_c;
    logic             pulse_edge_c;
    logic [CNT_W-1:0] cnt_next_c;
    logic [WIN_W-1:0] win_last_c;
    note_e            note_c;
    prox_e            prox_c;
    logic [CNT_W-1:0] target_c;
    logic [DIF_W-1:0] diff_c;
    logic [DIF_W-1:0] mag_c;
    logic             prox_select_c;
    logic [SEG_W-1:0] note_seg_c;
    logic [SEG_W-1:0] prox_seg_c;
    logic [SEG_W-1:0] seg_c;
    logic             unused_ok;

    assign cfg_c        = ui_in[4:2];
    assign cfg_change_c = (cfg_c != cfg_q);
    // sync_q[1] is the synchronized pulse, sync_q[2] its previous value
    assign pulse_edge_c = sync_q[1] & ~sync_q[2];
    assign cnt_next_c   = (pulse_edge_c && (pulse_cnt_q != CNT_MAX))
                          ? pulse_cnt_q + CNT_W'(1) : pulse_cnt_q;

    always_comb begin
        win_last_c = WIN_W'(999);
        case (cfg_q)
            3'd0:    win_last_c = WIN_W'(999);
            3'd1:    win_last_c = WIN_W'(1999);
            3'd2:    win_last_c = WIN_W'(3999);
            3'd3:    win_last_c = WIN_W'(7999);
            3'd4:    win_last_c = WIN_W'(9999);
            3'd5:    win_last_c = WIN_W'(39999);
            3'd6:    win_last_c = WIN_W'(49999);
            default: win_last_c = WIN_W'(59999);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], ui_in[5]};
        end
    end

    // Measurement window: a config change restarts it without latching
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q       <= '0;
            win_cnt_q   <= '0;
            pulse_cnt_q <= '0;
            lat_cnt_q   <= '0;
            lat_valid_q <= 1'b0;
        end else if (cfg_change_c) begin
            cfg_q       <= cfg_c;
            win_cnt_q   <= '0;
            pulse_cnt_q <= '0;
        end else if (win_cnt_q == win_last_c) begin
            win_cnt_q   <= '0;
            pulse_cnt_q <= '0;
            lat_cnt_q   <= cnt_next_c;
            lat_valid_q <= 1'b1;
        end else begin
            win_cnt_q   <= win_cnt_q + WIN_W'(1);
            pulse_cnt_q <= cnt_next_c;
        end
    end

    // Nearest string and signed deviation of the latched count
    always_comb begin
        note_c   = NOTE_NONE;
        prox_c   = PROX_NONE;
        target_c = '0;
        diff_c   = '0;
        mag_c    = '0;
        if (lat_valid_q && (lat_cnt_q >= CNT_W'(60)) && (lat_cnt_q <= CNT_W'(400))) begin
            if (lat_cnt_q <= CNT_W'(96)) begin
                note_c = NOTE_E2; target_c = CNT_W'(82);
            end else if (lat_cnt_q <= CNT_W'(128)) begin
                note_c = NOTE_A2; target_c = CNT_W'(110);
            end else if (lat_cnt_q <= CNT_W'(171)) begin
                note_c = NOTE_D3; target_c = CNT_W'(147);
            end else if (lat_cnt_q <= CNT_W'(221)) begin
                note_c = NOTE_G3; target_c = CNT_W'(196);
            end else if (lat_cnt_q <= CNT_W'(288)) begin
                note_c = NOTE_B3; target_c = CNT_W'(247);
            end else begin
                note_c = NOTE_E4; target_c = CNT_W'(330);
            end
            diff_c = DIF_W'(lat_cnt_q) - DIF_W'(target_c);
            mag_c  = diff_c[DIF_W-1] ? DIF_W'(-diff_c) : diff_c;
            if (mag_c <= DIF_W'(1)) begin
                prox_c = PROX_EXACT;
            end else if (mag_c <= DIF_W'(5)) begin
                prox_c = diff_c[DIF_W-1] ? PROX_CLOSE_LO : PROX_CLOSE_HI;
            end else begin
                prox_c = diff_c[DIF_W-1] ? PROX_FAR_LO : PROX_FAR_HI;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_q <= NOTE_NONE;
            prox_q <= PROX_NONE;
        end else begin
            note_q <= note_c;
            prox_q <= prox_c;
        end
    end

    // Display multiplexer: select flips every 8 clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= '0;
            prox_sel_q <= 1'b0;
        end else begin
            div_q <= div_q + DIV_W'(1);
            if (div_q == DIV_MAX) begin
                prox_sel_q <= ~prox_sel_q;
            end
        end
    end

    always_comb begin
        prox_select_c = ui_in[6] ? ui_in[7] : prox_sel_q;
        note_seg_c    = 7'b1000000;
        prox_seg_c    = 7'b0000000;
        case (note_q)
            NOTE_E2: note_seg_c = 7'b1111001;
            NOTE_A2: note_seg_c = 7'b1110111;
            NOTE_D3: note_seg_c = 7'b1011110;
            NOTE_G3: note_seg_c = 7'b0111101;
            NOTE_B3: note_seg_c = 7'b1111100;
            NOTE_E4: note_seg_c = 7'b1111011;
            default: note_seg_c = 7'b1000000;
        endcase
        case (prox_q)
            PROX_FAR_LO:   prox_seg_c = 7'b0110000;
            PROX_CLOSE_LO: prox_seg_c = 7'b0010000;
            PROX_EXACT:    prox_seg_c = 7'b1001001;
            PROX_CLOSE_HI: prox_seg_c = 7'b0000100;
            PROX_FAR_HI:   prox_seg_c = 7'b0000110;
            default:       prox_seg_c = 7'b0000000;
        endcase
        seg_c = prox_select_c ? prox_seg_c : note_seg_c;
    end

    assign uo_out    = {prox_select_c, seg_c};
    assign uio_out   = '0;
    assign uio_oe    = '0;
    assign unused_ok = &{1'b0, ena, uio_in, ui_in[1:0]};

endmodule

// File: tb/tb_neptune_proportional_tuner.sv
// Bench for neptune_proportional_tuner: pulse trains and bursts against a
// count-to-glyph reference model built from the tuning rules.
module tb_neptune_proportional_tuner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] cfg_sel;
    logic       pulse;
    logic       single_en;
    logic       single_sel;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [6:0] seg;
    logic       psel;

    int gen_period = 0;
    int burst_n    = 0;
    int burst_id   = 0;
    int checks     = 0;
    int errors     = 0;

    assign ui_in  = {single_sel, single_en, pulse, cfg_sel, 2'b00};
    assign uio_in = 8'h00;
    assign seg    = uo_out[6:0];
    assign psel   = uo_out[7];

    neptune_proportional_tuner dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (1'b1),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    // Pulse source: a requested burst of 2-clock pulses, else a periodic train
    initial begin
        int tick = 0;
        int left = 0;
        int seen = 0;
        pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (burst_id != seen) begin
                seen = burst_id;
                left = burst_n;
            end
            if (left > 0) begin
                if (!pulse) pulse = 1'b1;
                else begin
                    pulse = 1'b0;
                    left--;
                end
            end else if (gen_period > 0) begin
                pulse = ((tick % gen_period) < (gen_period / 2));
                tick++;
            end else begin
                pulse = 1'b0;
            end
        end
    end

    function automatic int win_len(input logic [2:0] c);
        int w[8];
        w = '{1000, 2000, 4000, 8000, 10000, 40000, 50000, 60000};
        return w[c];
    endfunction

    // Nearest target (ties go to the lower string), -1 when outside 60..400
    function automatic int nearest(input int n);
        int t[6];
        int best;
        t = '{82, 110, 147, 196, 247, 330};
        if (n < 60 || n > 400) return -1;
        best = 0;
        for (int i = 1; i < 6; i++) begin
            int a, b;
            a = (n > t[i]) ? n - t[i] : t[i] - n;
            b = (n > t[best]) ? n - t[best] : t[best] - n;
            if (a < b) best = i;
        end
        return best;
    endfunction

    function automatic logic [6:0] ref_note(input int n);
        logic [6:0] g[6];
        int idx;
        g = '{7'b1111001, 7'b1110111, 7'b1011110, 7'b0111101, 7'b1111100, 7'b1111011};
        idx = nearest(n);
        return (idx < 0) ? 7'b1000000 : g[idx];
    endfunction

    function automatic logic [6:0] ref_prox(input int n);
        int t[6];
        int idx, d;
        t = '{82, 110, 147, 196, 247, 330};
        idx = nearest(n);
        if (idx < 0) return 7'b0000000;
        d = n - t[idx];
        if (d >= -1 && d <= 1) return 7'b1001001;
        if (d >= -5 && d < 0)  return 7'b0010000;
        if (d > 0 && d <= 5)   return 7'b0000100;
        if (d < 0)             return 7'b0110000;
        return 7'b0000110;
    endfunction

    // Force a clean window start at the next clock edge
    task automatic restart_window(input logic [2:0] c);
        cfg_sel = c ^ 3'b001;
        @(negedge clk);
        cfg_sel = c;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        cfg_sel    = 3'b000;
        single_en  = 1'b0;
        single_sel = 1'b0;
        gen_period = 4;
        for (int i = 0; i < 3; i++) begin
            repeat (7) @(negedge clk);
            checks++;
            if (seg !== 7'b1000000 || psel !== 1'b0) begin
                errors++;
                $display("FAIL reset_out[%0d]: got seg=%b sel=%b want seg=1000000 sel=0", i, seg, psel);
            end
        end
        checks++;
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            errors++;
            $display("FAIL reset_uio: got out=%h oe=%h want 00/00", uio_out, uio_oe);
        end
        gen_period = 0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        single_en = 1'b1;
        repeat (1005) @(negedge clk);
        single_sel = 1'b0;
        #1;
        checks++;
        if (seg !== 7'b1000000 || psel !== 1'b0) begin
            errors++;
            $display("FAIL idle_note: got seg=%b sel=%b want seg=1000000 sel=0", seg, psel);
        end
        single_sel = 1'b1;
        #1;
        checks++;
        if (seg !== 7'b0000000 || psel !== 1'b1) begin
            errors++;
            $display("FAIL idle_prox: got seg=%b sel=%b want seg=0000000 sel=1", seg, psel);
        end
    endtask

    task automatic test_periodic();
        logic [2:0] cfgs[3];
        int         pers[3];
        cfgs = '{3'b000, 3'b010, 3'b100};
        pers = '{10, 20, 91};
        single_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int w, lo, hi;
            w  = win_len(cfgs[i]);
            lo = w / pers[i];
            hi = (w + pers[i] - 1) / pers[i];
            gen_period = pers[i];
            repeat (5) @(negedge clk);
            restart_window(cfgs[i]);
            repeat (w + 3) @(negedge clk);
            single_sel = 1'b0;
            #1;
            checks++;
            if ((seg !== ref_note(lo) && seg !== ref_note(hi)) || psel !== 1'b0) begin
                errors++;
                $display("FAIL periodic_note p=%0d: got seg=%b sel=%b want seg=%b sel=0", pers[i], seg, psel, ref_note(lo));
            end
            single_sel = 1'b1;
            #1;
            checks++;
            if ((seg !== ref_prox(lo) && seg !== ref_prox(hi)) || psel !== 1'b1) begin
                errors++;
                $display("FAIL periodic_prox p=%0d: got seg=%b sel=%b want seg=%b sel=1", pers[i], seg, psel, ref_prox(lo));
            end
        end
    endtask

    // Latched result is A2 exact from the 91-clock train on a 10000-clock window
    task automatic test_multiplex();
        logic prev, exp_sel;
        logic [6:0] exp_seg;
        bit found;
        single_en = 1'b0;
        @(negedge clk);
        prev  = psel;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (psel !== prev) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mux_toggle: got no select change in 12 clocks want one within 8");
        end else begin
            for (int j = 0; j < 32; j++) begin
                exp_sel = (~prev) ^ logic'((j / 8) % 2);
                exp_seg = exp_sel ? ref_prox(109) : ref_note(109);
                checks++;
                if (psel !== exp_sel || seg !== exp_seg) begin
                    errors++;
                    $display("FAIL mux_phase[%0d]: got sel=%b seg=%b want sel=%b seg=%b", j, psel, seg, exp_sel, exp_seg);
                end
                @(negedge clk);
            end
        end
        single_en = 1'b1;
    endtask

    task automatic test_no_note_and_restart();
        single_en = 1'b1;
        gen_period = 25;
        repeat (5) @(negedge clk);
        restart_window(3'b000);
        repeat (1003) @(negedge clk);
        single_sel = 1'b0;
        #1;
        checks++;
        if (seg !== ref_note(40)) begin
            errors++;
            $display("FAIL low_count_note: got %b want %b", seg, ref_note(40));
        end
        single_sel = 1'b1;
        #1;
        checks++;
        if (seg !== ref_prox(40)) begin
            errors++;
            $display("FAIL low_count_prox: got %b want %b", seg, ref_prox(40));
        end
        gen_period = 10;
        repeat (5) @(negedge clk);
        restart_window(3'b000);
        repeat (1003) @(negedge clk);
        single_sel = 1'b0;
        #1;
        checks++;
        if (seg !== ref_note(100)) begin
            errors++;
            $display("FAIL a2_note: got %b want %b", seg, ref_note(100));
        end
        gen_period = 25;
        repeat (200) @(negedge clk);
        cfg_sel = 3'b001;
        repeat (1200) @(negedge clk);
        single_sel = 1'b1;
        #1;
        checks++;
        if (seg !== ref_prox(100)) begin
            errors++;
            $display("FAIL restart_no_latch: got %b want %b", seg, ref_prox(100));
        end
        repeat (803) @(negedge clk);
        checks++;
        if (seg !== ref_prox(80)) begin
            errors++;
            $display("FAIL restart_prox: got %b want %b", seg, ref_prox(80));
        end
        single_sel = 1'b0;
        #1;
        checks++;
        if (seg !== ref_note(80)) begin
            errors++;
            $display("FAIL restart_note: got %b want %b", seg, ref_note(80));
        end
        gen_period = 0;
        repeat (5) @(negedge clk);
    endtask

    // Exact pulse counts in bursts; random cases are appended to the boundary list
    task automatic test_bursts(input int n_random);
        int list[$];
        list = '{0, 59, 60, 76, 77, 80, 81, 83, 87, 88, 96, 97, 128, 129,
                 171, 172, 221, 222, 288, 289, 330, 400, 401, 515};
        for (int r = 0; r < n_random; r++) list.push_back(int'($urandom_range(0, 520)));
        single_en = 1'b1;
        foreach (list[k]) begin
            logic [2:0] c;
            int n, m;
            n = list[k];
            m = (n > 511) ? 511 : n;
            c = (n > 480) ? 3'b001 : 3'b000;
            restart_window(c);
            burst_n = n;
            burst_id++;
            repeat (win_len(c) + 3) @(negedge clk);
            single_sel = 1'b0;
            #1;
            checks++;
            if (seg !== ref_note(m) || psel !== 1'b0) begin
                errors++;
                $display("FAIL burst_note n=%0d: got seg=%b sel=%b want seg=%b sel=0", n, seg, psel, ref_note(m));
            end
            single_sel = 1'b1;
            #1;
            checks++;
            if (seg !== ref_prox(m) || psel !== 1'b1) begin
                errors++;
                $display("FAIL burst_prox n=%0d: got seg=%b sel=%b want seg=%b sel=1", n, seg, psel, ref_prox(m));
            end
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_multiplex();
        test_no_note_and_restart();
        test_bursts(6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
